daa_regf_seq: RTL and testbench

DAA_REGF_SEQ -- requirements
Module: daa_regf_seq

---
 rtl/daa_regf_seq_pkg.sv | 30 +++
 rtl/daa_regf_seq.sv | 215 +++++++++++++++++++++
 tb/tb_daa_regf_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/daa_regf_seq_pkg.sv
// Shared definitions for the ENTDAA register-file sequencer.
// Holds the sequencer state encoding, default register-file map locations,
// counter widths and the ENTDAA CCC code.
package daa_regf_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    CNT_RD,
    CNT_WAIT,
    DA_RD,
    DA_WAIT,
    OFFER,
    FINISH
  } daa_state_e;

  // Default register-file map
  localparam int unsigned DA_BASE_DEF    = 80;
  localparam int unsigned COUNT_ADDR_DEF = 35;
  localparam int unsigned PID_BASE_DEF   = 420;
  localparam int unsigned MAX_TGTS_DEF   = 20;

  // Target index / count width and per-target log byte counter width
  localparam int unsigned TGT_W      = 5;
  localparam int unsigned BYTE_CNT_W = 3;

  // ENTDAA common command code
  localparam logic [7:0] ENTDAA_CCC = 8'h07;

endpackage

// File: rtl/daa_regf_seq.sv
// ENTDAA register-file sequencer.
// Reads the target count and per-target dynamic addresses from the register
// file, offers each address with odd parity to the bus engine, and logs the
// 8 captured PID/BCR/DCR bytes of every acknowledging target back into the
// register file.
// Ports:
//   i_daaseq_clk / i_daaseq_rst     clock, async active-high reset
//   i_daaseq_start / abort          pass control pulses
//   i_daaseq_nack                   no target acked the offered address
//   i_daaseq_byte_valid / byte      captured PID/BCR/DCR byte
//   i_daaseq_regf_data_rd           register-file read data (1-cycle latency)
//   o_daaseq_regf_rd_en/wr_en/addr/data_wr  register-file access
//   o_daaseq_da_byte / da_valid     address byte offered to the engine
//   o_daaseq_busy / done / assigned pass status
module daa_regf_seq
  import daa_regf_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR       = 10,
  parameter int unsigned MAX_TGTS   = MAX_TGTS_DEF,
  parameter int unsigned DA_BASE    = DA_BASE_DEF,
  parameter int unsigned COUNT_ADDR = COUNT_ADDR_DEF,
  parameter int unsigned PID_BASE   = PID_BASE_DEF
) (
  input  logic             i_daaseq_clk,
  input  logic             i_daaseq_rst,
  input  logic             i_daaseq_start,
  input  logic             i_daaseq_abort,
  input  logic             i_daaseq_nack,
  input  logic             i_daaseq_byte_valid,
  input  logic [WIDTH-1:0] i_daaseq_byte,
  input  logic [WIDTH-1:0] i_daaseq_regf_data_rd,
  output logic             o_daaseq_regf_rd_en,
  output logic             o_daaseq_regf_wr_en,
  output logic [ADDR-1:0]  o_daaseq_regf_addr,
  output logic [WIDTH-1:0] o_daaseq_regf_data_wr,
  output logic [WIDTH-1:0] o_daaseq_da_byte,
  output logic             o_daaseq_da_valid,
  output logic             o_daaseq_busy,
  output logic             o_daaseq_done,
  output logic [4:0]       o_daaseq_assigned
);

  daa_state_e            state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR-1:0]       addr_q, addr_d;
  logic [WIDTH-1:0]      data_wr_q, data_wr_d;
  logic [WIDTH-1:0]      da_byte_q, da_byte_d;
  logic                  da_valid_q, da_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [TGT_W-1:0]      assigned_q, assigned_d;
  logic [TGT_W-1:0]      index_q, index_d;
  logic [TGT_W-1:0]      count_q, count_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  last_q, last_d;

  logic [TGT_W-1:0]      idx_inc;
  logic [TGT_W-1:0]      cnt_clamp;
  logic [ADDR-1:0]       pid_addr;
  logic [ADDR-1:0]       da_addr_cur;
  logic [ADDR-1:0]       da_addr_nxt;

  // Address and count helpers
  assign idx_inc     = TGT_W'(index_q + TGT_W'(1));
  assign cnt_clamp   = (i_daaseq_regf_data_rd > WIDTH'(MAX_TGTS)) ? TGT_W'(MAX_TGTS)
                                                                  : TGT_W'(i_daaseq_regf_data_rd);
  assign pid_addr    = ADDR'(PID_BASE) + (ADDR'(index_q) << 3) + ADDR'(byte_cnt_q);
  assign da_addr_cur = ADDR'(DA_BASE) + ADDR'(index_q);
  assign da_addr_nxt = ADDR'(DA_BASE) + ADDR'(idx_inc);

  // State and output registers
  always_ff @(posedge i_daaseq_clk or posedge i_daaseq_rst) begin
    if (i_daaseq_rst) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_wr_q  <= '0;
      da_byte_q  <= '0;
      da_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      assigned_q <= '0;
      index_q    <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_wr_q  <= data_wr_d;
      da_byte_q  <= da_byte_d;
      da_valid_q <= da_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      assigned_q <= assigned_d;
      index_q    <= index_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
    end
  end

  // Next-state and next-output logic. Enables are computed one cycle ahead
  // so that they are high during the state that owns the access.
  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_wr_d  = data_wr_q;
    da_byte_d  = da_byte_q;
    da_valid_d = da_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    assigned_d = assigned_q;
    index_d    = index_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    last_d     = 1'b0;

    if (i_daaseq_abort && (state_q != IDLE)) begin
      // Abandon the pass; a byte arriving this cycle is not written
      state_d    = IDLE;
      da_valid_d = 1'b0;
      busy_d     = 1'b0;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_daaseq_start) begin
            state_d    = CNT_RD;
            index_d    = '0;
            assigned_d = '0;
            count_d    = '0;
            byte_cnt_d = '0;
            busy_d     = 1'b1;
            rd_en_d    = 1'b1;
            addr_d     = ADDR'(COUNT_ADDR);
          end
        end

        CNT_RD: state_d = CNT_WAIT;

        CNT_WAIT: begin
          count_d = cnt_clamp;
          if (cnt_clamp == '0) begin
            state_d = FINISH;
          end else begin
            state_d = DA_RD;
            rd_en_d = 1'b1;
            addr_d  = da_addr_cur;
          end
        end

        DA_RD: state_d = DA_WAIT;

        DA_WAIT: begin
          da_byte_d  = WIDTH'({i_daaseq_regf_data_rd[6:0], ~^i_daaseq_regf_data_rd[6:0]});
          da_valid_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = OFFER;
        end

        OFFER: begin
          if (last_q) begin
            // 8th log write is on the bus this cycle; move to the next target
            da_valid_d = 1'b0;
            index_d    = idx_inc;
            assigned_d = TGT_W'(assigned_q + TGT_W'(1));
            if (idx_inc == count_q) begin
              state_d = FINISH;
            end else begin
              state_d = DA_RD;
              rd_en_d = 1'b1;
              addr_d  = da_addr_nxt;
            end
          end else if (i_daaseq_byte_valid) begin
            wr_en_d    = 1'b1;
            addr_d     = pid_addr;
            data_wr_d  = i_daaseq_byte;
            byte_cnt_d = BYTE_CNT_W'(byte_cnt_q + BYTE_CNT_W'(1));
            last_d     = (byte_cnt_q == BYTE_CNT_W'(7));
          end else if (i_daaseq_nack && (byte_cnt_q == '0)) begin
            da_valid_d = 1'b0;
            state_d    = FINISH;
          end
        end

        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign o_daaseq_regf_rd_en   = rd_en_q;
  assign o_daaseq_regf_wr_en   = wr_en_q;
  assign o_daaseq_regf_addr    = addr_q;
  assign o_daaseq_regf_data_wr = data_wr_q;
  assign o_daaseq_da_byte      = da_byte_q;
  assign o_daaseq_da_valid     = da_valid_q;
  assign o_daaseq_busy         = busy_q;
  assign o_daaseq_done         = done_q;
  assign o_daaseq_assigned     = assigned_q;

endmodule

// File: tb/tb_daa_regf_seq.sv
// Directed self-checking bench for daa_regf_seq with a 1-cycle-latency
// register-file read model and negedge-sampled access/offer monitors.
module tb_daa_regf_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ADDR  = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             nack = 1'b0;
  logic             byte_valid = 1'b0;
  logic [WIDTH-1:0] byte_in = '0;
  logic [WIDTH-1:0] rdata;
  logic             rd_en, wr_en;
  logic [ADDR-1:0]  addr;
  logic [WIDTH-1:0] data_wr;
  logic [WIDTH-1:0] da_byte;
  logic             da_valid, busy, done;
  logic [4:0]       assigned;

  daa_regf_seq dut (
    .i_daaseq_clk          (clk),
    .i_daaseq_rst          (rst),
    .i_daaseq_start        (start),
    .i_daaseq_abort        (abort),
    .i_daaseq_nack         (nack),
    .i_daaseq_byte_valid   (byte_valid),
    .i_daaseq_byte         (byte_in),
    .i_daaseq_regf_data_rd (rdata),
    .o_daaseq_regf_rd_en   (rd_en),
    .o_daaseq_regf_wr_en   (wr_en),
    .o_daaseq_regf_addr    (addr),
    .o_daaseq_regf_data_wr (data_wr),
    .o_daaseq_da_byte      (da_byte),
    .o_daaseq_da_valid     (da_valid),
    .o_daaseq_busy         (busy),
    .o_daaseq_done         (done),
    .o_daaseq_assigned     (assigned)
  );

  always #5 clk = ~clk;

  // Register-file read model: data appears the cycle after rd_en
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
  end

  // Access / offer monitors
  int              rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0, done_cnt = 0, offer_cnt = 0;
  int              run = 0, max_run = 0;
  logic [ADDR-1:0] max_rd_addr = '0, last_rd_addr = '0;
  logic            prev_dav = 1'b0;
  logic [7:0]      da_q [$];
  logic [ADDR-1:0] wa_q [$];
  logic [7:0]      wd_q [$];

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_cnt++;
      last_rd_addr = addr;
      if (addr > max_rd_addr) max_rd_addr = addr;
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wa_q.push_back(addr);
      wd_q.push_back(data_wr);
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rd_en === 1'b1 && wr_en === 1'b1) ovl_cnt++;
    if (done === 1'b1) done_cnt++;
    if (da_valid === 1'b1 && prev_dav !== 1'b1) begin
      offer_cnt++;
      da_q.push_back(da_byte);
    end
    prev_dav = da_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'(base + 8'(i));
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_offers(input string tag, input int target);
    for (int i = 0; i < 60 && offer_cnt < target; i++) @(negedge clk);
    chk(tag, offer_cnt, target);
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 60 && done_cnt < target; i++) @(negedge clk);
    chk(tag, done_cnt, target);
  endtask

  initial begin
    int rb, wb, ob, db, qb, bad;
    logic [7:0] exp_d;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_da_valid", da_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_assigned", assigned, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two targets, full logs, back-to-back bytes
    mem[35] = 8'd2; mem[80] = 8'h03; mem[81] = 8'h04;
    rb = rd_cnt; wb = wr_cnt; ob = offer_cnt; db = done_cnt; qb = wa_q.size();
    do_start();
    chk("t1_busy", busy, 1);
    wait_offers("t1_offer0", ob + 1);
    chk("t1_da0", da_q[ob], 8'h07);
    send_bytes(8, 8'h10);
    wait_offers("t1_offer1", ob + 2);
    chk("t1_da1", da_q[ob + 1], 8'h08);
    send_bytes(8, 8'h20);
    wait_done("t1_done", db + 1);
    chk("t1_wr_cnt", wr_cnt - wb, 16);
    chk("t1_rd_cnt", rd_cnt - rb, 3);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 8) ? 8'(8'h10 + i) : 8'(8'h20 + i - 8);
      if (wa_q[qb + i] !== 10'(420 + i) || wd_q[qb + i] !== exp_d) bad++;
    end
    chk("t1_wr_seq", bad, 0);
    chk("t1_wr_run", max_run, 8);
    chk("t1_overlap", ovl_cnt, 0);
    chk("t1_assigned", assigned, 2);
    chk("t1_busy_end", busy, 0);

    // Zero targets
    mem[35] = 8'd0;
    rb = rd_cnt; wb = wr_cnt; ob = offer_cnt; db = done_cnt;
    do_start();
    wait_done("t2_done", db + 1);
    chk("t2_rd_cnt", rd_cnt - rb, 1);
    chk("t2_rd_addr", last_rd_addr, 35);
    chk("t2_wr_cnt", wr_cnt - wb, 0);
    chk("t2_offers", offer_cnt - ob, 0);
    chk("t2_assigned", assigned, 0);

    // Three targets, nack on the second offer
    mem[35] = 8'd3; mem[82] = 8'h05;
    wb = wr_cnt; ob = offer_cnt; db = done_cnt; qb = wa_q.size();
    do_start();
    wait_offers("t3_offer0", ob + 1);
    send_bytes(8, 8'h30);
    wait_offers("t3_offer1", ob + 2);
    nack = 1'b1;
    @(negedge clk);
    nack = 1'b0;
    wait_done("t3_done", db + 1);
    repeat (3) @(negedge clk);
    chk("t3_done_once", done_cnt - db, 1);
    chk("t3_wr_cnt", wr_cnt - wb, 8);
    chk("t3_wr_first", wa_q[qb], 420);
    chk("t3_wr_last", wa_q[qb + 7], 427);
    chk("t3_assigned", assigned, 1);
    chk("t3_da_valid", da_valid, 0);

    // Abort after the 3rd byte; a nack mid-log is ignored
    mem[35] = 8'd2;
    wb = wr_cnt; ob = offer_cnt; db = done_cnt;
    do_start();
    wait_offers("t4_offer0", ob + 1);
    send_bytes(3, 8'h40);
    nack = 1'b1;
    @(negedge clk);
    nack = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_da_valid", da_valid, 0);
    rb = rd_cnt;
    chk("t4_wr_cnt", wr_cnt - wb, 3);
    repeat (10) @(negedge clk);
    chk("t4_no_rd", rd_cnt - rb, 0);
    chk("t4_no_wr", wr_cnt - wb, 3);
    chk("t4_no_done", done_cnt - db, 0);
    chk("t4_assigned", assigned, 0);

    // Normal pass after abort
    mem[35] = 8'd1; mem[80] = 8'h05;
    wb = wr_cnt; ob = offer_cnt; db = done_cnt; qb = wa_q.size();
    do_start();
    wait_offers("t5_offer0", ob + 1);
    chk("t5_da0", da_q[ob], 8'h0B);
    send_bytes(8, 8'h50);
    wait_done("t5_done", db + 1);
    chk("t5_wr_cnt", wr_cnt - wb, 8);
    chk("t5_wr_last", wa_q[qb + 7], 427);
    chk("t5_wr_data", wd_q[qb + 7], 8'h57);
    chk("t5_assigned", assigned, 1);

    // Count clamp, start ignored while busy
    mem[35] = 8'd25;
    for (int i = 0; i < 25; i++) mem[80 + i] = 8'(i + 1);
    rb = rd_cnt; wb = wr_cnt; ob = offer_cnt; db = done_cnt;
    do_start();
    wait_offers("t6_offer0", ob + 1);
    do_start();
    for (int t = 0; t < 20; t++) begin
      wait_offers("t6_offer", ob + t + 1);
      send_bytes(8, 8'(t * 8));
    end
    wait_done("t6_done", db + 1);
    repeat (3) @(negedge clk);
    chk("t6_done_once", done_cnt - db, 1);
    chk("t6_assigned", assigned, 20);
    chk("t6_rd_cnt", rd_cnt - rb, 21);
    chk("t6_max_rd", max_rd_addr, 99);
    chk("t6_wr_cnt", wr_cnt - wb, 160);
    chk("t6_wr_last", wa_q[wa_q.size() - 1], 579);
    chk("t6_offers", offer_cnt - ob, 20);

    // Reset mid-pass: no accesses afterwards
    mem[35] = 8'd1;
    ob = offer_cnt;
    do_start();
    wait_offers("t7_offer0", ob + 1);
    send_bytes(2, 8'h60);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rb = rd_cnt; wb = wr_cnt;
    repeat (10) @(negedge clk);
    chk("t7_no_rd", rd_cnt - rb, 0);
    chk("t7_no_wr", wr_cnt - wb, 0);
    chk("t7_busy", busy, 0);
    chk("t7_assigned", assigned, 0);
    chk("t7_overlap", ovl_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
